// File: rtl/regfile_pkg.sv
// Shared register-file definitions: geometry defaults, FSM states and read-path selects.
package regfile_pkg;

  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned RF_DEPTH  = 32;

  typedef enum logic {
    RF_ST_INIT,
    RF_ST_READY
  } rf_state_e;

  // Which source drives a read port after the edge; chosen alongside the RAM read.
  typedef enum logic [1:0] {
    RD_SEL_ZERO,
    RD_SEL_BYP,
    RD_SEL_RAM
  } rd_sel_e;

endpackage

// File: rtl/regfile_ram.sv
// 2-read/1-write synchronous-read storage with no reset, shaped for block-RAM inference.
module regfile_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr1,
  input  logic [ADDR_W-1:0] i_raddr2,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [DATA_W-1:0] o_rdata2
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Read-before-write on address collision; the top level bypasses that case.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    o_rdata1 <= r_mem[i_raddr1];
    o_rdata2 <= r_mem[i_raddr2];
  end

endmodule

// File: rtl/regfile.sv
// Integer register file: WB write port, two registered ID read ports, x0 hardwired,
// same-cycle write bypass, and a post-reset init sequencer that clears x1..x31.
module regfile
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = RF_DATA_W,
  parameter int unsigned ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_reg_wen,
  input  logic [ADDR_W-1:0] wb_reg_waddr,
  input  logic [DATA_W-1:0] wb_reg_wdata,
  input  logic [ADDR_W-1:0] id_rs1_addr,
  input  logic [ADDR_W-1:0] id_rs2_addr,
  output logic [DATA_W-1:0] rf_rs1_rdata,
  output logic [DATA_W-1:0] rf_rs2_rdata,
  output logic              rf_busy
);

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  rf_state_e         r_state;
  rf_state_e         w_state_nxt;
  logic [ADDR_W-1:0] r_init_idx;

  logic              w_busy;
  logic              w_commit;
  logic              w_ram_we;
  logic [ADDR_W-1:0] w_ram_waddr;
  logic [DATA_W-1:0] w_ram_wdata;
  logic [DATA_W-1:0] w_ram_rd1;
  logic [DATA_W-1:0] w_ram_rd2;

  rd_sel_e           w_rs1_sel;
  rd_sel_e           w_rs2_sel;
  rd_sel_e           r_rs1_sel;
  rd_sel_e           r_rs2_sel;
  logic [DATA_W-1:0] r_byp_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RF_ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == RF_ST_INIT && r_init_idx == LAST_IDX) begin
      w_state_nxt = RF_ST_READY;
    end
  end

  always_comb begin
    w_busy      = (r_state == RF_ST_INIT);
    w_commit    = (r_state == RF_ST_READY) && wb_reg_wen && (wb_reg_waddr != '0);
    w_ram_we    = w_busy || w_commit;
    w_ram_waddr = w_busy ? r_init_idx : wb_reg_waddr;
    w_ram_wdata = w_busy ? '0 : wb_reg_wdata;
  end

  // Saturates at the last index; it is not consulted once READY.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_init_idx <= ADDR_W'(1);
    end else if (r_state == RF_ST_INIT && r_init_idx != LAST_IDX) begin
      r_init_idx <= r_init_idx + ADDR_W'(1);
    end
  end

  regfile_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .i_clk    (clk),
    .i_we     (w_ram_we),
    .i_waddr  (w_ram_waddr),
    .i_wdata  (w_ram_wdata),
    .i_raddr1 (id_rs1_addr),
    .i_raddr2 (id_rs2_addr),
    .o_rdata1 (w_ram_rd1),
    .o_rdata2 (w_ram_rd2)
  );

  always_comb begin
    w_rs1_sel = RD_SEL_RAM;
    if (w_busy || id_rs1_addr == '0) begin
      w_rs1_sel = RD_SEL_ZERO;
    end else if (w_commit && wb_reg_waddr == id_rs1_addr) begin
      w_rs1_sel = RD_SEL_BYP;
    end
    w_rs2_sel = RD_SEL_RAM;
    if (w_busy || id_rs2_addr == '0) begin
      w_rs2_sel = RD_SEL_ZERO;
    end else if (w_commit && wb_reg_waddr == id_rs2_addr) begin
      w_rs2_sel = RD_SEL_BYP;
    end
  end

  // Select state resets to ZERO so both outputs read 0 the moment reset asserts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rs1_sel <= RD_SEL_ZERO;
      r_rs2_sel <= RD_SEL_ZERO;
    end else begin
      r_rs1_sel <= w_rs1_sel;
      r_rs2_sel <= w_rs2_sel;
    end
  end

  always_ff @(posedge clk) begin
    r_byp_data <= wb_reg_wdata;
  end

  always_comb begin
    unique case (r_rs1_sel)
      RD_SEL_BYP: rf_rs1_rdata = r_byp_data;
      RD_SEL_RAM: rf_rs1_rdata = w_ram_rd1;
      default:    rf_rs1_rdata = '0;
    endcase
    unique case (r_rs2_sel)
      RD_SEL_BYP: rf_rs2_rdata = r_byp_data;
      RD_SEL_RAM: rf_rs2_rdata = w_ram_rd2;
      default:    rf_rs2_rdata = '0;
    endcase
  end

  assign rf_busy = w_busy;

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: vector table plus hand sequences for init and reset.
module tb_regfile;

  logic        clk;
  logic        rst;
  logic        wb_reg_wen;
  logic [4:0]  wb_reg_waddr;
  logic [31:0] wb_reg_wdata;
  logic [4:0]  id_rs1_addr;
  logic [4:0]  id_rs2_addr;
  logic [31:0] rf_rs1_rdata;
  logic [31:0] rf_rs2_rdata;
  logic        rf_busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  typedef struct {
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;

  vec_t  vecs [12];
  exp_t  sb [$];
  string sb_name [$];

  regfile #(
    .DATA_W (32),
    .ADDR_W (5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wb_reg_wen   (wb_reg_wen),
    .wb_reg_waddr (wb_reg_waddr),
    .wb_reg_wdata (wb_reg_wdata),
    .id_rs1_addr  (id_rs1_addr),
    .id_rs2_addr  (id_rs2_addr),
    .rf_rs1_rdata (rf_rs1_rdata),
    .rf_rs2_rdata (rf_rs2_rdata),
    .rf_busy      (rf_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic wen, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] a1, input logic [4:0] a2);
    wb_reg_wen   = wen;
    wb_reg_waddr = wa;
    wb_reg_wdata = wd;
    id_rs1_addr  = a1;
    id_rs2_addr  = a2;
  endtask

  // One cycle: drive at negedge, queue the expectation, compare after the next rising edge.
  task automatic step(input logic wen, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [4:0] a1, input logic [4:0] a2,
                      input logic [31:0] e1, input logic [31:0] e2, input string nm);
    exp_t  e;
    string n;
    @(negedge clk);
    drive(wen, wa, wd, a1, a2);
    sb.push_back('{e1, e2});
    sb_name.push_back(nm);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    n = sb_name.pop_front();
    check({n, "_rs1"}, rf_rs1_rdata, e.e1);
    check({n, "_rs2"}, rf_rs2_rdata, e.e2);
  endtask

  task automatic wait_init(input string nm);
    int   n;
    logic done;
    n    = 0;
    done = 1'b0;
    while (!done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      check({nm, "_init_rs1"}, rf_rs1_rdata, 32'h0);
      check({nm, "_init_rs2"}, rf_rs2_rdata, 32'h0);
      if (!rf_busy) done = 1'b1;
    end
    check({nm, "_busy_cycles"}, 32'(n), 32'd31);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd1,  5'd17, 32'h0,        32'h0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd6,  32'hDEADBEEF, 32'h0};
    vecs[2]  = '{1'b1, 5'd7,  32'h12345678, 5'd7,  5'd7,  32'h12345678, 32'h12345678};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd5,  32'h12345678, 32'hDEADBEEF};
    vecs[4]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd31, 32'h0,        32'h0};
    vecs[6]  = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd30, 32'hA5A5A5A5, 32'h0};
    vecs[7]  = '{1'b1, 5'd5,  32'h11111111, 5'd5,  5'd31, 32'h11111111, 32'hA5A5A5A5};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,        5'd3,  5'd5,  32'h0,        32'h11111111};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'h11111111, 32'h11111111};
    vecs[10] = '{1'b1, 5'd9,  32'hCAFEF00D, 5'd1,  5'd9,  32'h0,        32'hCAFEF00D};
    vecs[11] = '{1'b0, 5'd9,  32'h00000BAD, 5'd9,  5'd2,  32'hCAFEF00D, 32'h0};

    rst = 1'b0;
    drive(1'b1, 5'd3, 32'h000000AA, 5'd3, 5'd3);
    #3;
    check("reset_busy", 32'(rf_busy), 32'd1);
    check("reset_rs1", rf_rs1_rdata, 32'h0);
    check("reset_rs2", rf_rs2_rdata, 32'h0);

    @(negedge clk);
    rst = 1'b1;
    wait_init("first");

    // First external write lands on the edge right after busy drops.
    step(1'b1, 5'd4, 32'h0BADF00D, 5'd4, 5'd4, 32'h0BADF00D, 32'h0BADF00D, "edge32_bypass");
    step(1'b0, 5'd0, 32'h0, 5'd4, 5'd3, 32'h0BADF00D, 32'h0, "edge32_store_x3dropped");
    step(1'b0, 5'd0, 32'h0, 5'd1, 5'd17, 32'h0, 32'h0, "cleared_x1_x17");
    step(1'b0, 5'd0, 32'h0, 5'd31, 5'd31, 32'h0, 32'h0, "cleared_x31");

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].wen, vecs[i].waddr, vecs[i].wdata, vecs[i].rs1, vecs[i].rs2,
           vecs[i].e1, vecs[i].e2, $sformatf("vec%0d", i));
    end

    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
    @(posedge clk);
    #1;
    check("pre_reset_rs1", rf_rs1_rdata, 32'hCAFEF00D);
    #2;
    rst = 1'b0;
    #1;
    check("midreset_busy", 32'(rf_busy), 32'd1);
    check("midreset_rs1", rf_rs1_rdata, 32'h0);
    check("midreset_rs2", rf_rs2_rdata, 32'h0);
    @(posedge clk);
    @(negedge clk);
    drive(1'b1, 5'd3, 32'h000000AA, 5'd3, 5'd9);
    rst = 1'b1;
    wait_init("second");

    step(1'b0, 5'd0, 32'h0, 5'd9, 5'd7, 32'h0, 32'h0, "reinit_x9_x7");
    step(1'b0, 5'd0, 32'h0, 5'd5, 5'd3, 32'h0, 32'h0, "reinit_x5_x3");
    step(1'b0, 5'd0, 32'h0, 5'd31, 5'd4, 32'h0, 32'h0, "reinit_x31_x4");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
